// File: rtl/reg_op_pkg.sv
// reg_op_pkg: shared widths, opcodes, state encoding and latched-operation type for reg_op_seq.
package reg_op_pkg;
  localparam int RW = 3;
  localparam int DW = 8;
  localparam logic [2:0] OP_LDI = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD1  = 2'd1;
  localparam logic [1:0] ST_RD2  = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;
  typedef struct packed {
    logic [2:0]    opcode;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [DW-1:0] imm;
  } op_t;
  function automatic logic skips_reads(input logic [2:0] opc);
    return opc == OP_LDI || opc == OP_NOP;
  endfunction
endpackage

// File: rtl/reg_op_alu.sv
// reg_op_alu: combinational 8-bit result for one register operation, modulo 256.
module reg_op_alu
  import reg_op_pkg::*;
(
  input  logic [2:0]    opcode,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] y
);
  always_comb
    y = opcode == OP_LDI ? imm :
        opcode == OP_MOV ? opa :
        opcode == OP_ADD ? opa + opb :
        opcode == OP_SUB ? opa - opb :
        opcode == OP_AND ? opa & opb :
        opcode == OP_OR  ? opa | opb :
        opcode == OP_XOR ? opa ^ opb : '0;
endmodule

// File: rtl/reg_op_seq.sv
// reg_op_seq: sequences one register op into read-port/write-port cycles of an 8x8 register file.
// Optional REG_OP_SEQ_ZFLAG_EN adds a zero flag updated on every writing op.
module reg_op_seq
  import reg_op_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    opcode,
  input  logic [RW-1:0] rd,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [DW-1:0] imm,
  input  logic [RW-1:0] mon_sel,
  output logic [RW-1:0] rf_rsel,
  input  logic [DW-1:0] rf_q,
  output logic [RW-1:0] rf_wsel,
  output logic          rf_en,
  output logic [DW-1:0] rf_d,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result
`ifdef REG_OP_SEQ_ZFLAG_EN
  ,
  output logic          zflag
`endif
);
  logic [1:0]    state;
  op_t           op;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic [DW-1:0] alu_y;
  logic          accept;
  logic          wb_write;
  reg_op_alu u_alu (
    .opcode(op.opcode),
    .opa   (opa),
    .opb   (opb),
    .imm   (op.imm),
    .y     (alu_y)
  );
  always_comb begin
    accept   = state == ST_IDLE && op_valid;
    wb_write = state == ST_WB && op.opcode != OP_NOP;
    op_ready = state == ST_IDLE && !clr;
    busy     = state != ST_IDLE;
    done     = state == ST_WB && !clr;
    rf_rsel  = state == ST_RD1 ? op.rs1 : state == ST_RD2 ? op.rs2 : mon_sel;
    rf_wsel  = op.rd;
    rf_d     = alu_y;
    // Gated by clr so a reset in WB can never commit a write.
    rf_en    = wb_write && !clr;
  end
  always_ff @(posedge clk)
    if (clr) begin
      state  <= ST_IDLE;
      op     <= '0;
      opa    <= '0;
      opb    <= '0;
      result <= '0;
    end else begin
      state <= state == ST_IDLE ? (op_valid ? (skips_reads(opcode) ? ST_WB : ST_RD1) : ST_IDLE) :
               state == ST_RD1  ? (op.opcode == OP_MOV ? ST_WB : ST_RD2) :
               state == ST_RD2  ? ST_WB : ST_IDLE;
      if (accept) op <= {opcode, rd, rs1, rs2, imm};
      if (state == ST_RD1) opa <= rf_q;
      if (state == ST_RD2) opb <= rf_q;
      if (wb_write) result <= alu_y;
    end
`ifdef REG_OP_SEQ_ZFLAG_EN
  always_ff @(posedge clk)
    if (clr) zflag <= 1'b0;
    else if (wb_write) zflag <= alu_y == '0;
`endif
endmodule

// File: tb/tb_reg_op_seq.sv
// tb_reg_op_seq: randomized self-checking bench with a behavioural register file and op model.
module tb_reg_op_seq;
  import reg_op_pkg::*;
  logic       clk = 0;
  logic       clr = 1;
  logic       op_valid = 0;
  logic [2:0] opcode = 0, rd = 0, rs1 = 0, rs2 = 0, mon_sel = 0;
  logic [7:0] imm = 0;
  logic       op_ready, rf_en, busy, done;
  logic [2:0] rf_rsel, rf_wsel;
  logic [7:0] rf_q, rf_d, result;
`ifdef REG_OP_SEQ_ZFLAG_EN
  logic       zflag;
`endif
  logic [7:0] rf [8];
  logic [7:0] m_rf [8];
  logic [7:0] m_res = 0;
  logic       m_z = 0;
  int n_chk = 0;
  int n_fail = 0;

  reg_op_seq dut (
    .clk(clk), .clr(clr), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .mon_sel(mon_sel),
    .rf_rsel(rf_rsel), .rf_q(rf_q), .rf_wsel(rf_wsel), .rf_en(rf_en), .rf_d(rf_d),
    .busy(busy), .done(done), .result(result)
`ifdef REG_OP_SEQ_ZFLAG_EN
    , .zflag(zflag)
`endif
  );

  always #5 clk = ~clk;
  assign rf_q = rf[rf_rsel];
  always @(posedge clk)
    if (clr) for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    else if (rf_en) rf[rf_wsel] <= rf_d;

  function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input logic [7:0] i);
    case (o)
      OP_LDI:  return i;
      OP_MOV:  return a;
      OP_ADD:  return 8'((int'(a) + int'(b)) % 256);
      OP_SUB:  return 8'((int'(a) - int'(b) + 256) % 256);
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mon_sel = 3'(i);
      #1;
      n_chk++;
      if (rf_q !== m_rf[i]) begin
        n_fail++;
        $display("FAIL %s r%0d: got %h want %h", tag, i, rf_q, m_rf[i]);
      end
    end
  endtask

  task automatic check_one(input string tag, input logic [2:0] r, input logic [7:0] want);
    @(negedge clk);
    mon_sel = r;
    #1;
    n_chk++;
    if (rf_q !== want) begin
      n_fail++;
      $display("FAIL %s r%0d: got %h want %h", tag, r, rf_q, want);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2, input logic [7:0] im);
    int lat, exp_lat;
    logic [7:0] exp_v;
    exp_lat = (o == OP_LDI || o == OP_NOP) ? 1 : (o == OP_MOV) ? 2 : 3;
    exp_v = model(o, m_rf[s1], m_rf[s2], im);
    @(negedge clk);
    opcode = o; rd = d; rs1 = s1; rs2 = s2; imm = im; op_valid = 1;
    n_chk++;
    if (op_ready !== 1'b1) begin n_fail++; $display("FAIL accept_ready: got %b want 1", op_ready); end
    @(posedge clk);
    #1 op_valid = 0;
    opcode = 3'($urandom); rd = 3'($urandom); rs1 = 3'($urandom); rs2 = 3'($urandom); imm = 8'($urandom);
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (done) break;
      n_chk++;
      if (op_ready !== 1'b0 || busy !== 1'b1 || rf_en !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_ctl: ready=%b busy=%b en=%b want 0 1 0", op_ready, busy, rf_en);
      end
    end
    n_chk++;
    if (lat != exp_lat || done !== 1'b1) begin
      n_fail++;
      $display("FAIL latency op%0d: got %0d done=%b want %0d", o, lat, done, exp_lat);
    end
    n_chk++;
    if (rf_en !== (o != OP_NOP) || op_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wb_en op%0d: en=%b ready=%b want en=%b ready=0", o, rf_en, op_ready, o != OP_NOP);
    end
    if (o != OP_NOP) begin
      n_chk++;
      if (rf_wsel !== d || rf_d !== exp_v) begin
        n_fail++;
        $display("FAIL wb_data: wsel=%0d d=%h want %0d %h", rf_wsel, rf_d, d, exp_v);
      end
      m_rf[d] = exp_v;
      m_res = exp_v;
      m_z = exp_v == 8'h00;
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0 || op_ready !== 1'b1 || result !== m_res) begin
      n_fail++;
      $display("FAIL post_wb: done=%b busy=%b ready=%b result=%h want 0 0 1 %h", done, busy, op_ready, result, m_res);
    end
`ifdef REG_OP_SEQ_ZFLAG_EN
    n_chk++;
    if (zflag !== m_z) begin n_fail++; $display("FAIL zflag: got %b want %b", zflag, m_z); end
`endif
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    clr = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || rf_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b result=%h en=%b want 0 0 00 0", busy, done, result, rf_en);
    end
    clr = 0;
    #1;
    n_chk++;
    if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", op_ready); end
`ifdef REG_OP_SEQ_ZFLAG_EN
    n_chk++;
    if (zflag !== 1'b0) begin n_fail++; $display("FAIL reset_zflag: got %b want 0", zflag); end
`endif
    check_regs("reset_regs");
  endtask

  task automatic test_ldi();
    do_op(OP_LDI, 3, 0, 0, 8'h5A);
    check_one("ldi_r3", 3, 8'h5A);
  endtask

  task automatic test_add_wrap();
    do_op(OP_LDI, 1, 0, 0, 8'hF0);
    do_op(OP_LDI, 2, 0, 0, 8'h20);
    do_op(OP_ADD, 4, 1, 2, 8'h00);
    check_one("add_wrap", 4, 8'h10);
    do_op(OP_LDI, 2, 0, 0, 8'h10);
    do_op(OP_ADD, 4, 1, 2, 8'h00);
    check_one("add_zero", 4, 8'h00);
  endtask

  task automatic test_sub();
    do_op(OP_LDI, 2, 0, 0, 8'h01);
    do_op(OP_LDI, 1, 0, 0, 8'h02);
    do_op(OP_SUB, 5, 2, 1, 8'h00);
    check_one("sub_borrow", 5, 8'hFF);
  endtask

  task automatic test_self();
    do_op(OP_LDI, 2, 0, 0, 8'h41);
    do_op(OP_ADD, 2, 2, 2, 8'h00);
    check_one("self_add", 2, 8'h82);
  endtask

  task automatic test_nop();
    do_op(OP_NOP, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
    check_regs("nop_regs");
  endtask

  task automatic test_busy_ignore();
    logic [7:0] exp_v;
    exp_v = model(OP_ADD, m_rf[1], m_rf[2], 8'h00);
    @(negedge clk);
    opcode = OP_ADD; rd = 7; rs1 = 1; rs2 = 2; op_valid = 1;
    @(posedge clk);
    #1 opcode = OP_LDI; rd = 0; imm = 8'hEE;
    repeat (2) @(posedge clk);
    #1 op_valid = 0;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || rf_wsel !== 3'd7) begin
      n_fail++;
      $display("FAIL busy_ignore_wb: done=%b wsel=%0d want 1 7", done, rf_wsel);
    end
    m_rf[7] = exp_v;
    m_res = exp_v;
    m_z = exp_v == 8'h00;
    check_regs("busy_ignore_regs");
  endtask

  task automatic test_back_to_back();
    logic [7:0] ims [4];
    int acc [$];
    int k, cyc;
    logic r;
    for (int i = 0; i < 4; i++) ims[i] = 8'($urandom);
    @(negedge clk);
    opcode = OP_LDI; rd = 0; imm = ims[0]; op_valid = 1;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      r = op_ready;
      @(posedge clk);
      cyc++;
      if (r && op_valid) begin
        acc.push_back(cyc);
        m_rf[k] = ims[k];
        m_res = ims[k];
        m_z = ims[k] == 8'h00;
        k++;
        #1;
        if (k < 4) begin rd = 3'(k); imm = ims[k]; end
        else op_valid = 0;
      end
    end
    op_valid = 0;
    n_chk++;
    if (acc.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      n_chk++;
      if (acc[i] - acc[i-1] != 2) begin
        n_fail++;
        $display("FAIL b2b_spacing %0d: got %0d want 2", i, acc[i] - acc[i-1]);
      end
    end
    @(negedge clk);
    check_regs("b2b_regs");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      do_op(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
    check_regs("random_regs");
  endtask

  task automatic test_clr_mid();
    do_op(OP_LDI, 1, 0, 0, 8'h33);
    do_op(OP_LDI, 2, 0, 0, 8'h44);
    @(negedge clk);
    opcode = OP_ADD; rd = 6; rs1 = 1; rs2 = 2; op_valid = 1;
    @(posedge clk);
    #1 op_valid = 0;
    @(negedge clk);
    @(negedge clk);
    clr = 1;
    #1;
    n_chk++;
    if (rf_en !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_rd2: en=%b done=%b want 0 0", rf_en, done);
    end
    @(posedge clk);
    #1 clr = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    m_res = 8'h00;
    m_z = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (op_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rf_en !== 1'b0 || result !== 8'h00) begin
        n_fail++;
        $display("FAIL clr_after c%0d: ready=%b busy=%b done=%b en=%b result=%h want 1 0 0 0 00",
                 c, op_ready, busy, done, rf_en, result);
      end
    end
    check_regs("clr_regs");
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add_wrap();
    test_sub();
    test_self();
    test_nop();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_clr_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
